// File: rtl/bram_copy_ctrl.sv
// Streams N words from a source BRAM port to a destination BRAM port, one read per cycle,
// and pulses done to both memories when the last write has landed.
module bram_copy_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 13,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_copied,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_en,
  output logic [3:0]            src_we,
  output logic                  src_rst,
  output logic                  src_done,
  input  logic [31:0]           src_rddata,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  dst_en,
  output logic [3:0]            dst_we,
  output logic [31:0]           dst_wrdata,
  output logic                  dst_rst,
  output logic                  dst_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  rem_reg;
  logic [CNT_WIDTH-1:0]  words_reg;
  logic [ADDR_WIDTH-1:0] src_addr_reg;
  logic [ADDR_WIDTH-1:0] dst_ptr_reg;
  logic                  src_en_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  pipe_v_reg [RD_LAT];
  logic [ADDR_WIDTH-1:0] pipe_a_reg [RD_LAT];
  logic                  upstream_pending;

  // Reads still travelling toward the tail stage; the tail itself is written this cycle.
  always_comb begin
    upstream_pending = 1'b0;
    for (int j = 0; j < RD_LAT - 1; j++) begin
      upstream_pending = upstream_pending | pipe_v_reg[j];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_words == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (rem_reg == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!upstream_pending) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      words_reg    <= '0;
      src_addr_reg <= '0;
      dst_ptr_reg  <= '0;
      src_en_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      for (int j = 0; j < RD_LAT; j++) begin
        pipe_v_reg[j] <= 1'b0;
        pipe_a_reg[j] <= '0;
      end
    end else begin
      state_reg <= state_next;
      // A zero-length job is busy only for its single FINISH cycle.
      busy_reg  <= (state_next == READ) || (state_next == DRAIN) ||
                   ((state_reg == IDLE) && start);
      done_reg  <= (state_next == FINISH);

      case (state_reg)
        IDLE: begin
          if (start && (num_words != '0)) begin
            src_en_reg   <= 1'b1;
            src_addr_reg <= src_base & ALIGN_MASK;
            dst_ptr_reg  <= dst_base & ALIGN_MASK;
            rem_reg      <= num_words - 1'b1;
          end
        end
        READ: begin
          if (rem_reg == '0) begin
            src_en_reg   <= 1'b0;
            src_addr_reg <= '0;
          end else begin
            src_addr_reg <= src_addr_reg + STEP;
            dst_ptr_reg  <= dst_ptr_reg + STEP;
            rem_reg      <= rem_reg - 1'b1;
          end
        end
        default: ;
      endcase

      if ((state_reg == IDLE) && start) begin
        words_reg <= '0;
      end else if (pipe_v_reg[RD_LAT-1]) begin
        words_reg <= words_reg + 1'b1;
      end

      // Destination address rides alongside the read it belongs to.
      pipe_v_reg[0] <= src_en_reg;
      pipe_a_reg[0] <= src_en_reg ? dst_ptr_reg : '0;
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_v_reg[j] <= pipe_v_reg[j-1];
        pipe_a_reg[j] <= pipe_a_reg[j-1];
      end
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign words_copied = words_reg;
  assign src_addr     = src_addr_reg;
  assign src_en       = src_en_reg;
  assign src_we       = 4'b0000;
  assign src_rst      = 1'b0;
  assign src_done     = done_reg;
  assign dst_en       = pipe_v_reg[RD_LAT-1];
  assign dst_addr     = pipe_a_reg[RD_LAT-1];
  assign dst_we       = {4{pipe_v_reg[RD_LAT-1]}};
  assign dst_wrdata   = src_rddata;
  assign dst_rst      = 1'b0;
  assign dst_done     = done_reg;

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Directed bench: two controllers (read latency 1 and 2) share stimulus, each with its own
// source read pipeline and destination memory image.
module tb_bram_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] src_base, dst_base;
  logic [12:0] num_words;

  logic        a_busy, a_done, a_src_en, a_src_rst, a_src_done, a_dst_en, a_dst_rst, a_dst_done;
  logic [12:0] a_wc;
  logic [14:0] a_src_addr, a_dst_addr;
  logic [3:0]  a_src_we, a_dst_we;
  logic [31:0] a_src_rddata, a_dst_wrdata, a_rd1;

  logic        b_busy, b_done, b_src_en, b_src_rst, b_src_done, b_dst_en, b_dst_rst, b_dst_done;
  logic [12:0] b_wc;
  logic [14:0] b_src_addr, b_dst_addr;
  logic [3:0]  b_src_we, b_dst_we;
  logic [31:0] b_src_rddata, b_dst_wrdata, b_rd1, b_rd2;

  logic [31:0] srcmem [8192];
  logic [31:0] dmem_a [8192];
  logic [31:0] dmem_b [8192];
  int          wr_a = 0;
  int          wr_b = 0;
  int          n_checks = 0;
  int          n_fails  = 0;

  logic [15:0] a_obs, b_obs;
  assign a_obs = {a_busy, a_done, a_src_done, a_dst_done, a_src_en, a_dst_en,
                  a_dst_we, a_src_we, a_src_rst, a_dst_rst};
  assign b_obs = {b_busy, b_done, b_src_done, b_dst_done, b_src_en, b_dst_en,
                  b_dst_we, b_src_we, b_src_rst, b_dst_rst};

  always #5 clk = ~clk;

  bram_copy_ctrl #(.ADDR_WIDTH(15), .CNT_WIDTH(13), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .num_words(num_words), .busy(a_busy), .done(a_done), .words_copied(a_wc),
    .src_addr(a_src_addr), .src_en(a_src_en), .src_we(a_src_we), .src_rst(a_src_rst),
    .src_done(a_src_done), .src_rddata(a_src_rddata), .dst_addr(a_dst_addr),
    .dst_en(a_dst_en), .dst_we(a_dst_we), .dst_wrdata(a_dst_wrdata), .dst_rst(a_dst_rst),
    .dst_done(a_dst_done));

  bram_copy_ctrl #(.ADDR_WIDTH(15), .CNT_WIDTH(13), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .num_words(num_words), .busy(b_busy), .done(b_done), .words_copied(b_wc),
    .src_addr(b_src_addr), .src_en(b_src_en), .src_we(b_src_we), .src_rst(b_src_rst),
    .src_done(b_src_done), .src_rddata(b_src_rddata), .dst_addr(b_dst_addr),
    .dst_en(b_dst_en), .dst_we(b_dst_we), .dst_wrdata(b_dst_wrdata), .dst_rst(b_dst_rst),
    .dst_done(b_dst_done));

  assign a_src_rddata = a_rd1;
  assign b_src_rddata = b_rd2;

  always @(posedge clk) begin
    if (a_src_en) a_rd1 <= srcmem[a_src_addr[14:2]];
    if (a_dst_en && (a_dst_we == 4'hF)) dmem_a[a_dst_addr[14:2]] <= a_dst_wrdata;
    if (a_dst_en) wr_a <= wr_a + 1;
    if (b_src_en) b_rd1 <= srcmem[b_src_addr[14:2]];
    b_rd2 <= b_rd1;
    if (b_dst_en && (b_dst_we == 4'hF)) dmem_b[b_dst_addr[14:2]] <= b_dst_wrdata;
    if (b_dst_en) wr_b <= wr_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one job and check it cycle by cycle on the instance with latency lat.
  // poke_at: cycle carrying an extra start with different parameters; abort_at: cycle of reset.
  task automatic run_job(input string name, input int lat, input logic [14:0] sb,
                         input logic [14:0] db, input int n, input int poke_at,
                         input int abort_at);
    logic [15:0] obs, exp;
    logic [14:0] e_addr;
    bit          e_src, e_dst, e_done, e_busy;
    int          last, wr0, idx;
    logic [31:0] e_data, o_data;
    last = (n == 0) ? 1 : n + lat + 1;
    repeat (3) @(negedge clk);
    wr0 = (lat == 1) ? wr_a : wr_b;
    src_base = sb; dst_base = db; num_words = 13'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      if (c > 1) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("%s rst ctl_a", name), {16'h0, a_obs}, 32'h0);
        chk($sformatf("%s rst ctl_b", name), {16'h0, b_obs}, 32'h0);
        chk($sformatf("%s rst addr", name), {2'b0, a_src_addr, a_dst_addr}, 32'h0);
        chk($sformatf("%s rst wc", name), {6'b0, a_wc, b_wc}, 32'h0);
        repeat (3) @(negedge clk);
        chk($sformatf("%s rst writes", name), wr_a - wr0, abort_at - 2);
        rst_n = 1'b1;
        return;
      end
      if (c == poke_at) begin
        src_base = 15'h5550; dst_base = 15'h0A00; num_words = 13'd3; start = 1'b1;
      end
      e_src  = (c <= n);
      e_dst  = (c > lat) && (c <= n + lat);
      e_done = (c == last);
      e_busy = (n == 0) ? (c == 1) : (c <= n + lat);
      exp = {e_busy, e_done, e_done, e_done, e_src, e_dst, {4{e_dst}}, 4'b0, 1'b0, 1'b0};
      obs = (lat == 1) ? a_obs : b_obs;
      chk($sformatf("%s c%0d ctl", name, c), {16'h0, obs}, {16'h0, exp});
      if (e_src) begin
        e_addr = (sb & 15'h7FFC) + 15'(4 * (c - 1));
        chk($sformatf("%s c%0d src_addr", name, c),
            {17'h0, (lat == 1) ? a_src_addr : b_src_addr}, {17'h0, e_addr});
      end
      if (e_dst) begin
        e_addr = (db & 15'h7FFC) + 15'(4 * (c - lat - 1));
        chk($sformatf("%s c%0d dst_addr", name, c),
            {17'h0, (lat == 1) ? a_dst_addr : b_dst_addr}, {17'h0, e_addr});
      end
      if (e_done) begin
        chk($sformatf("%s words_copied", name), {19'h0, (lat == 1) ? a_wc : b_wc}, n);
      end
    end
    chk($sformatf("%s writes", name), ((lat == 1) ? wr_a : wr_b) - wr0, n);
    for (int k = 0; k < n; k++) begin
      idx    = ((int'(db) >> 2) + k) % 8192;
      e_data = 32'hA500_0000 + 32'(((int'(sb) >> 2) + k) % 8192);
      o_data = (lat == 1) ? dmem_a[idx] : dmem_b[idx];
      chk($sformatf("%s data[%0d]", name, k), o_data, e_data);
    end
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) srcmem[k] = 32'hA500_0000 + 32'(k);
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; num_words = '0;
    repeat (2) @(negedge clk);
    chk("reset ctl_a", {16'h0, a_obs}, 32'h0);
    chk("reset ctl_b", {16'h0, b_obs}, 32'h0);
    chk("reset addr", {2'b0, a_src_addr, a_dst_addr}, 32'h0);
    chk("reset wc", {6'b0, a_wc, b_wc}, 32'h0);
    rst_n = 1'b1;

    run_job("copy32", 1, 15'h0000, 15'h0000, 32, 0, 0);
    run_job("zero",   1, 15'h0040, 15'h0080, 0,  0, 0);
    run_job("wrap",   1, 15'h7FF8, 15'h0100, 4,  0, 0);
    run_job("busy",   1, 15'h0400, 15'h1000, 16, 5, 0);
    run_job("abort",  1, 15'h0800, 15'h2000, 32, 0, 10);
    run_job("after",  1, 15'h0C00, 15'h3000, 8,  0, 0);
    run_job("lat2",   2, 15'h0040, 15'h0200, 8,  0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
